// File: rtl/button_conditioner_if.sv
// Button-side signal bundle for button_conditioner: raw active-low inputs in,
// debounced levels and one-clock event pulses out.
interface button_conditioner_if;
  logic [5:0] btn_raw_n;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       long_reset;
  logic       long_test;
  logic [1:0] hold_active;

  modport master (
    output btn_raw_n,
    input  btn_level, btn_press, long_reset, long_test, hold_active
  );

  modport slave (
    input  btn_raw_n,
    output btn_level, btn_press, long_reset, long_test, hold_active
  );
endinterface

// File: rtl/button_conditioner.sv
// Six-channel pushbutton conditioner: 2-flop synchronizer, per-channel debounce FSM,
// press pulses on channels 0-3 and long-hold pulses on channels 4-5.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 250000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT,
    LONG_DONE
  } state_e;

  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic [5:0] btnIn;
  logic [5:0] levelVec;
  logic [5:0] pulseVec;

  // Synchronizer flops idle at the released (high) level of the raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.btn_raw_n;
      sync2_q <= sync1_q;
    end
  end

  assign btnIn = ~sync2_q;

  for (genvar i = 0; i < 6; i++) begin : g_ch
    localparam bit IS_LONG = (i >= 4);

    state_e        state_q, state_d;
    logic [DW-1:0] dbCnt_q, dbCnt_d;
    logic          fromLong_q, fromLong_d;
    logic          pulse_q, pulse_d;
    logic          holdHit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= IDLE;
        dbCnt_q    <= '0;
        fromLong_q <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        dbCnt_q    <= dbCnt_d;
        fromLong_q <= fromLong_d;
        pulse_q    <= pulse_d;
      end
    end

    // Long-hold detection takes priority over the release debounce window.
    always_comb begin
      state_d    = state_q;
      dbCnt_d    = (dbCnt_q == '1) ? dbCnt_q : dbCnt_q + 1'b1;
      fromLong_d = fromLong_q;
      pulse_d    = 1'b0;
      case (state_q)
        IDLE: begin
          if (btnIn[i]) begin
            state_d = PRESS_WAIT;
            dbCnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btnIn[i]) begin
            state_d = IDLE;
          end else if (dbCnt_q == DB_LAST) begin
            state_d = HELD;
            pulse_d = !IS_LONG;
          end
        end
        HELD: begin
          if (holdHit) begin
            state_d = LONG_DONE;
            pulse_d = 1'b1;
          end else if (!btnIn[i]) begin
            state_d    = RELEASE_WAIT;
            dbCnt_d    = '0;
            fromLong_d = 1'b0;
          end
        end
        LONG_DONE: begin
          if (!btnIn[i]) begin
            state_d    = RELEASE_WAIT;
            dbCnt_d    = '0;
            fromLong_d = 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (holdHit && !fromLong_q) begin
            state_d = LONG_DONE;
            pulse_d = 1'b1;
          end else if (btnIn[i]) begin
            state_d = fromLong_q ? LONG_DONE : HELD;
          end else if (dbCnt_q == DB_LAST) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (IS_LONG) begin : g_hold
      logic [LW-1:0] holdCnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          holdCnt_q <= '0;
        end else if (state_q == PRESS_WAIT && state_d == HELD) begin
          holdCnt_q <= '0;
        end else if ((state_q == HELD || (state_q == RELEASE_WAIT && !fromLong_q))
                     && holdCnt_q != '1) begin
          holdCnt_q <= holdCnt_q + 1'b1;
        end
      end

      assign holdHit = (holdCnt_q == LONG_LAST);
    end else begin : g_short
      assign holdHit = 1'b0;
    end

    assign levelVec[i] = (state_q == HELD) || (state_q == RELEASE_WAIT) || (state_q == LONG_DONE);
    assign pulseVec[i] = pulse_q;
  end

  assign bus.btn_level   = levelVec[3:0];
  assign bus.btn_press   = pulseVec[3:0];
  assign bus.long_reset  = pulseVec[4];
  assign bus.long_test   = pulseVec[5];
  assign bus.hold_active = levelVec[5:4];

endmodule
